pc_sequencer: RTL

Program-counter sequencer for the core's fetch stage. Holds the 12-bit PC, steps it each unstalled cycle, and resolves taken branches by presenting a 5-bit branch key to `branch_lut` and loading the returned target. Also handles start/halt control, flags branches whose key maps to no target, and keeps a saturating executed-instruction count. Sits between the instruction decoder (branch/halt/stall inputs) and instruction memory (`pc` output).

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/pc_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch-stage program-counter logic.
//   pc_t            : program counter / branch target word
//   branch_key_t    : decoder branch key presented to branch_lut
//   seq_state_t     : pc_sequencer run-state
//   BRANCH_UNMAPPED : branch_lut target code meaning "key has no target"
package cpu_pkg;

    localparam int unsigned PC_WIDTH  = 12;
    localparam int unsigned KEY_WIDTH = 5;

    typedef logic [PC_WIDTH-1:0]  pc_t;
    typedef logic [KEY_WIDTH-1:0] branch_key_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        FAULT
    } seq_state_t;

    localparam int unsigned BRANCH_UNMAPPED = 0;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage.
// Holds the PC, steps it every unstalled RUN cycle, resolves taken branches
// through the external branch_lut in the same cycle, and counts executed
// instructions (saturating).
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_start                 begin a run (ignored while running)
//   i_stall                 freeze PC/counter this cycle
//   i_halt                  current instruction ends the program
//   i_branch_en/_taken      branch present / condition true
//   i_branch_key            decoder branch key
//   i_branch_pos            target returned by branch_lut
//   o_branch_lut_en, o_key  combinational request to branch_lut
//   o_pc                    registered program counter
//   o_running/o_done/o_fault registered state decodes
//   o_instr_count           saturating executed-instruction count
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = 12,
    parameter int unsigned     KEY_W    = 5,
    parameter logic [PC_W-1:0] START_PC = '0,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_stall,
    input  logic              i_halt,
    input  logic              i_branch_en,
    input  logic              i_branch_taken,
    input  logic [KEY_W-1:0]  i_branch_key,
    input  logic [PC_W-1:0]   i_branch_pos,
    output logic              o_branch_lut_en,
    output logic [KEY_W-1:0]  o_key,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_running,
    output logic              o_done,
    output logic              o_fault,
    output logic [CNT_W-1:0]  o_instr_count
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_lut_en;

    // Kept outside the next-state block: key -> branch_lut -> branch_pos
    // feeds back into the PC mux, so the request must not depend on it.
    assign w_lut_en = (r_state == RUN) & ~i_stall & ~i_halt
                    & i_branch_en & i_branch_taken;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RUN: begin
                if (!i_stall) begin
                    w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
                    if (i_halt) begin
                        w_state_nxt = DONE;
                    end else if (w_lut_en) begin
                        // Target 0 is the LUT's unmapped-key code.
                        if (i_branch_pos == PC_W'(BRANCH_UNMAPPED))
                            w_state_nxt = FAULT;
                        else
                            w_pc_nxt = i_branch_pos;
                    end else if (r_pc == '1) begin
                        w_state_nxt = FAULT;
                    end else begin
                        w_pc_nxt = r_pc + 1'b1;
                    end
                end
            end
            default: begin
                if (i_start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = START_PC;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_branch_lut_en = w_lut_en;
    assign o_key           = w_lut_en ? i_branch_key : '0;
    assign o_pc            = r_pc;
    assign o_running       = (r_state == RUN);
    assign o_done          = (r_state == DONE);
    assign o_fault         = (r_state == FAULT);
    assign o_instr_count   = r_cnt;

endmodule
